// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// Module   : serializer
// Brief    : Zero-latency word-to-element serializer; emits elements 0..len of
//            the offered word and consumes it on the last element transfer.
// Revision : 1.0 - initial release
// ============================================================================
module serializer #(
    parameter int NUM = 4,
    parameter int W   = 8,
    localparam int LW = $clog2(NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [NUM*W+LW-1:0] din_data,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [W:0]          dout_data
);

    // Element table padded to a power of two so any cnt value selects safely.
    localparam int c_slots = 2 ** LW;

    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;
    logic [W-1:0]  w_elem [c_slots];
    logic [LW-1:0] w_len;
    logic          w_xfer;
    logic          w_last;

    generate
        for (genvar k = 0; k < c_slots; k++) begin : g_elem
            if (k < NUM) begin : g_live
                assign w_elem[k] = din_data[k*W +: W];
            end else begin : g_pad
                assign w_elem[k] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_len      = din_data[NUM*W +: LW];
        w_xfer     = din_valid & dout_ready;
        // ">=" rather than "==" so a length shrunk under an in-flight word
        // still terminates it instead of wrapping through the full count.
        w_last     = (cnt_q >= w_len);
        dout_valid = din_valid;
        dout_data  = {(cnt_q == w_len), w_elem[cnt_q]};
        din_ready  = w_xfer & w_last & ~rst;
        cnt_d      = cnt_q;
        if (w_xfer) begin
            cnt_d = w_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 The block SHALL have parameter NUM, default 4, meaning the number of elements per input word (legal range 2..256).
REQ-002 The block SHALL have parameter W, default 8, meaning the element width in bits.
REQ-003 The block SHALL derive localparam LW = $clog2(NUM), meaning the width of the length field.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The block SHALL have port din_valid, input, 1 bit, meaning an input word is offered.
REQ-007 The block SHALL have port din_ready, output, 1 bit, meaning the input word is consumed this cycle.
REQ-008 The block SHALL have port din_data, input, NUM*W+LW bits: element k at [k*W +: W]; field [NUM*W +: LW] = active element count minus 1.
REQ-009 The block SHALL have port dout_valid, output, 1 bit, meaning an output element is offered.
REQ-010 The block SHALL have port dout_ready, input, 1 bit, meaning the downstream accepts the element.
REQ-011 The block SHALL have port dout_data, output, W+1 bits: [W-1:0] = element, bit W = eot (last element of the word).

Function
REQ-012 The block SHALL hold an element index register cnt of LW bits, initially 0.
REQ-013 The block SHALL compute len = din_data[NUM*W +: LW]; active elements are indices 0..len.
REQ-014 The block SHALL drive dout_valid = din_valid combinationally (zero-latency, no data register).
REQ-015 The block SHALL drive dout_data[W-1:0] = din_data[cnt*W +: W] and dout_data[W] = (cnt == len).
REQ-016 The block SHALL define transfer = dout_valid & dout_ready.
REQ-017 On transfer with cnt != len the block SHALL increment cnt by 1 and keep din_ready low.
REQ-018 On transfer with cnt == len the block SHALL assert din_ready in that same cycle and load cnt with 0 on the next edge.
REQ-019 The block SHALL hold din_ready low in every cycle without a last-element transfer; din_ready SHALL never assert when din_valid is low.
REQ-020 With len = 0 the block SHALL emit exactly one element with eot = 1 and consume the word on that transfer.
REQ-021 The block SHALL ignore elements above index len; they are never emitted.
REQ-022 While dout_valid & ~dout_ready the block SHALL keep cnt and dout_data stable (upstream holds din_data stable while din_valid is high).
REQ-023 If len changes while cnt > len (protocol violation) the block SHALL treat the next transfer as last, assert din_ready and clear cnt; no lock-up.
REQ-024 Back-to-back words SHALL flow without a bubble: the element 0 of the next word is offered in the cycle after the last transfer.
REQ-025 Throughput SHALL be one element per cycle when dout_ready is held high.

Reset
REQ-026 Asserting rst SHALL clear cnt to 0 immediately, independent of clk.
REQ-027 During reset din_ready SHALL be 0; dout_valid and dout_data follow din_valid/din_data with cnt = 0.
REQ-028 Reset mid-word SHALL abandon the partial word; after release element 0 of the currently offered word is emitted first.

Verification
REQ-029 NUM=4, W=8, word {len=3, elems 0x11,0x22,0x33,0x44}, dout_ready=1 -> 0x11,0x22,0x33 eot=0, 0x44 eot=1 on four consecutive cycles; din_ready high only in cycle 4.
REQ-030 Word with len=0, elem0=0xAA -> single output 0xAA eot=1, din_ready high in that cycle.
REQ-031 Two back-to-back words (len=1 then len=2), dout_ready=1 -> five outputs with eot on 2nd and 5th, no idle cycle between words.
REQ-032 len=3 word, dout_ready toggled 1,0,0,1,1,0,1 -> dout_data stable during stalls, elements in order, eot only on 4th transfer.
REQ-033 rst pulsed asynchronously after 2nd element of a len=3 word -> cnt=0 immediately, din_ready=0 during reset, next transfer after release is element 0.
REQ-034 Random valid/ready over 10000 words with random len -> output stream equals scoreboard of active elements, one eot per word, din_ready count equals words sent.
